// File: rtl/digital_clock_rtc.sv
// digital_clock_rtc: prescaled hh:mm:ss real-time clock, 24-hour internal count.
// Adds time load with range check, 12/24-hour display, day-wrap pulse, optional alarm.
//
// Optional feature macro: DIGITAL_CLOCK_ALARM_EN (adds the alarm ports and logic)
//
// Ports:
//   Clk, reset_n                           clock, async active-low reset
//   set_en, set_hours/minutes/seconds      time load (24-hour form)
//   mode_12h                               display format select
//   alarm_set, alarm_hours/minutes,
//   alarm_on, alarm_ack, alarm             alarm (DIGITAL_CLOCK_ALARM_EN only)
//   seconds, minutes, hours, pm            displayed time
//   sec_tick, day_wrap, set_err            one-cycle registered pulses
module digital_clock_rtc #(
    parameter int CLK_DIV = 100,
    parameter int DIV_W   = 24
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    input  logic       mode_12h,
`ifdef DIGITAL_CLOCK_ALARM_EN
    input  logic       alarm_set,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    input  logic       alarm_on,
    input  logic       alarm_ack,
    output logic       alarm,
`endif
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       set_err
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [5:0]       sec_q;
    logic [5:0]       min_q;
    logic [4:0]       hr_q;

    logic       tick;
    logic       load_ok;
    logic       load_bad;
    logic [5:0] nsec;
    logic [5:0] nmin;
    logic [4:0] nhr;
    logic       nwrap;

    assign tick     = (div == DIV_MAX);
    assign load_ok  = set_en && (set_hours <= 5'd23) &&
                      (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
    assign load_bad = set_en && !load_ok;

    // Time one second ahead of the current count, with carries.
    always_comb begin
        nsec  = sec_q + 6'd1;
        nmin  = min_q;
        nhr   = hr_q;
        nwrap = 1'b0;
        if (sec_q == 6'd59) begin
            nsec = 6'd0;
            nmin = min_q + 6'd1;
            if (min_q == 6'd59) begin
                nmin = 6'd0;
                nhr  = hr_q + 5'd1;
                if (hr_q == 5'd23) begin
                    nhr   = 5'd0;
                    nwrap = 1'b1;
                end
            end
        end
    end

`ifdef DIGITAL_CLOCK_ALARM_EN
    logic [4:0] al_hr;
    logic [5:0] al_min;
    logic       al_ok;
    logic       al_bad;
    logic       al_hit;

    assign al_ok  = (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
    assign al_bad = alarm_set && !al_ok;
    // Only a counted second can fire the alarm; a load never does.
    assign al_hit = tick && !load_ok && alarm_on &&
                    (nhr == al_hr) && (nmin == al_min) &&
                    (nsec == 6'd0);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hr  <= 5'd0;
            al_min <= 6'd0;
            alarm  <= 1'b0;
        end else begin
            if (alarm_set && al_ok) begin
                al_hr  <= alarm_hours;
                al_min <= alarm_minutes;
            end
            // A hit takes priority over a simultaneous ack.
            if (al_hit) begin
                alarm <= 1'b1;
            end else if (alarm_ack) begin
                alarm <= 1'b0;
            end
        end
    end
`else
    logic al_bad;
    assign al_bad = 1'b0;
`endif

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            div      <= '0;
            sec_q    <= 6'd0;
            min_q    <= 6'd0;
            hr_q     <= 5'd0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            set_err  <= 1'b0;
        end else begin
            set_err  <= load_bad || al_bad;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            if (load_ok) begin
                // Load restarts the second and swallows any tick.
                div   <= '0;
                sec_q <= set_seconds;
                min_q <= set_minutes;
                hr_q  <= set_hours;
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tick) begin
                    sec_q    <= nsec;
                    min_q    <= nmin;
                    hr_q     <= nhr;
                    sec_tick <= 1'b1;
                    day_wrap <= nwrap;
                end
            end
        end
    end

    assign seconds = sec_q;
    assign minutes = min_q;

    // Display mapping; the internal count stays in 24-hour form.
    always_comb begin
        hours = hr_q;
        pm    = 1'b0;
        if (mode_12h) begin
            pm = (hr_q >= 5'd12);
            if (hr_q == 5'd0) begin
                hours = 5'd12;
            end else if (hr_q > 5'd12) begin
                hours = hr_q - 5'd12;
            end
        end
    end

endmodule

// File: tb/tb_digital_clock_rtc.sv
// tb_digital_clock_rtc: directed bench for digital_clock_rtc (CLK_DIV=4).
// Seconds-of-day reference model checked every cycle, plus literal checks.
module tb_digital_clock_rtc;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_en = 1'b0;
    logic [4:0] set_hours = '0;
    logic [5:0] set_minutes = '0;
    logic [5:0] set_seconds = '0;
    logic       mode_12h = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic       sec_tick;
    logic       day_wrap;
    logic       set_err;
`ifdef DIGITAL_CLOCK_ALARM_EN
    logic       alarm_set = 1'b0;
    logic [4:0] alarm_hours = '0;
    logic [5:0] alarm_minutes = '0;
    logic       alarm_on = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       alarm;
`endif

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    digital_clock_rtc #(.CLK_DIV(CLK_DIV), .DIV_W(24)) dut (
        .Clk(clk),
        .reset_n(rst_n),
        .set_en(set_en),
        .set_hours(set_hours),
        .set_minutes(set_minutes),
        .set_seconds(set_seconds),
        .mode_12h(mode_12h),
`ifdef DIGITAL_CLOCK_ALARM_EN
        .alarm_set(alarm_set),
        .alarm_hours(alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_on(alarm_on),
        .alarm_ack(alarm_ack),
        .alarm(alarm),
`endif
        .seconds(seconds),
        .minutes(minutes),
        .hours(hours),
        .pm(pm),
        .sec_tick(sec_tick),
        .day_wrap(day_wrap),
        .set_err(set_err)
    );

    // Reference model: time as seconds-of-day, phase within the second.
    int m_t = 0;
    int m_ph = 0;
    bit m_tick = 0;
    bit m_wrap = 0;
    bit m_err = 0;
    bit m_alarm = 0;
    int m_at = 0;

    always @(posedge clk or negedge rst_n) begin
        int nt;
        bit ok;
        bit bad;
        bit tk;
        bit hit;
        if (!rst_n) begin
            m_t <= 0;
            m_ph <= 0;
            m_tick <= 0;
            m_wrap <= 0;
            m_err <= 0;
            m_alarm <= 0;
            m_at <= 0;
        end else begin
            ok = set_en && set_hours < 24 && set_minutes < 60 &&
                 set_seconds < 60;
            bad = set_en && !ok;
            tk = !ok && (m_ph == CLK_DIV - 1);
            nt = ok ? set_hours * 3600 + set_minutes * 60 + set_seconds
                    : (tk ? (m_t + 1) % 86400 : m_t);
            hit = 0;
`ifdef DIGITAL_CLOCK_ALARM_EN
            hit = tk && alarm_on && (nt == m_at);
            if (alarm_set) begin
                if (alarm_hours < 24 && alarm_minutes < 60)
                    m_at <= alarm_hours * 3600 + alarm_minutes * 60;
                else
                    bad = 1;
            end
            m_alarm <= hit ? 1'b1 : (alarm_ack ? 1'b0 : m_alarm);
`endif
            m_t <= nt;
            m_ph <= ok ? 0 : (m_ph + 1) % CLK_DIV;
            m_tick <= tk;
            m_wrap <= tk && (nt == 0);
            m_err <= bad;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int disp_h(int t, bit m12);
        int h;
        h = t / 3600;
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_sec", {26'd0, seconds}, m_t % 60);
            check("cyc_min", {26'd0, minutes}, (m_t / 60) % 60);
            check("cyc_hr", {27'd0, hours}, disp_h(m_t, mode_12h));
            check("cyc_pm", {31'd0, pm}, mode_12h && m_t >= 12 * 3600);
            check("cyc_tick", {31'd0, sec_tick}, m_tick);
            check("cyc_wrap", {31'd0, day_wrap}, m_wrap);
            check("cyc_err", {31'd0, set_err}, m_err);
`ifdef DIGITAL_CLOCK_ALARM_EN
            check("cyc_alarm", {31'd0, alarm}, m_alarm);
`endif
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(int h, int m, int s);
        set_hours = 5'(h);
        set_minutes = 6'(m);
        set_seconds = 6'(s);
        set_en = 1'b1;
        step(1);
        set_en = 1'b0;
    endtask

    task automatic wait_tick(string name);
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            step(1);
            if (sec_tick === 1'b1) return;
        end
        check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic align_tick();
        for (int i = 0; i < CLK_DIV + 1; i++) begin
            if (m_ph == CLK_DIV - 1) return;
            step(1);
        end
    endtask

    task automatic hms(string name, int h, int m, int s);
        check({name, "_h"}, {27'd0, hours}, h);
        check({name, "_m"}, {26'd0, minutes}, m);
        check({name, "_s"}, {26'd0, seconds}, s);
    endtask

    int ld_h[3] = '{0, 12, 23};
    int ld_m[3] = '{0, 30, 15};
    int e12[3] = '{12, 12, 11};
    int epm[3] = '{0, 1, 1};

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values in both display modes.
        #3;
        hms("rst", 0, 0, 0);
        check("rst_tick", {31'd0, sec_tick}, 0);
        mode_12h = 1'b1;
        #1;
        check("rst_h12", {27'd0, hours}, 12);
        check("rst_pm12", {31'd0, pm}, 0);
        mode_12h = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // First advance CLK_DIV edges after release.
        step(CLK_DIV - 1);
        check("pre_tick", {31'd0, sec_tick}, 0);
        check("pre_sec", {26'd0, seconds}, 0);
        step(1);
        check("tick1", {31'd0, sec_tick}, 1);
        check("sec1", {26'd0, seconds}, 1);
        step(CLK_DIV);
        check("tick2", {31'd0, sec_tick}, 1);
        check("sec2", {26'd0, seconds}, 2);

        // Carries and day wrap.
        load(10, 59, 59);
        wait_tick("mcarry");
        hms("mcarry", 11, 0, 0);
        load(23, 59, 58);
        hms("ld235958", 23, 59, 58);
        check("ld_notick", {31'd0, sec_tick}, 0);
        wait_tick("wrap_a");
        hms("wrap_a", 23, 59, 59);
        check("wrap_a_dw", {31'd0, day_wrap}, 0);
        wait_tick("wrap_b");
        hms("wrap_b", 0, 0, 0);
        check("wrap_b_dw", {31'd0, day_wrap}, 1);
        step(1);
        check("wrap_dw_low", {31'd0, day_wrap}, 0);

        // 12-hour mapping and mode switch without count change.
        for (int i = 0; i < 3; i++) begin
            mode_12h = 1'b1;
            load(ld_h[i], ld_m[i], 0);
            check("m12_h", {27'd0, hours}, e12[i]);
            check("m12_pm", {31'd0, pm}, epm[i]);
            mode_12h = 1'b0;
            #1;
            check("m24_h", {27'd0, hours}, ld_h[i]);
            check("m24_pm", {31'd0, pm}, 0);
            check("m24_min", {26'd0, minutes}, ld_m[i]);
            #1;
        end

        // Rejected loads.
        load(10, 20, 30);
        load(24, 0, 0);
        check("err_h", {31'd0, set_err}, 1);
        hms("err_h", 10, 20, 30);
        step(1);
        check("err_h_low", {31'd0, set_err}, 0);
        load(10, 20, 30);
        load(10, 60, 0);
        check("err_m", {31'd0, set_err}, 1);
        hms("err_m", 10, 20, 30);
        step(1);
        check("err_m_low", {31'd0, set_err}, 0);

        // Load on the tick edge drops the tick.
        align_tick();
        load(8, 9, 10);
        check("coin_tick", {31'd0, sec_tick}, 0);
        hms("coin", 8, 9, 10);
        step(CLK_DIV - 1);
        check("coin_sec", {26'd0, seconds}, 10);
        step(1);
        check("coin_tick2", {31'd0, sec_tick}, 1);
        check("coin_sec2", {26'd0, seconds}, 11);

        // Held set_en freezes the clock.
        set_hours = 5'd1;
        set_minutes = 6'd2;
        set_seconds = 6'd3;
        set_en = 1'b1;
        step(3 * CLK_DIV);
        hms("hold", 1, 2, 3);
        set_en = 1'b0;

`ifdef DIGITAL_CLOCK_ALARM_EN
        alarm_hours = 5'd24;
        alarm_minutes = 6'd0;
        alarm_set = 1'b1;
        step(1);
        alarm_set = 1'b0;
        check("al_err", {31'd0, set_err}, 1);
        alarm_hours = 5'd7;
        alarm_set = 1'b1;
        step(1);
        alarm_set = 1'b0;
        check("al_ok", {31'd0, set_err}, 0);
        alarm_on = 1'b1;
        load(6, 59, 59);
        check("al_pre", {31'd0, alarm}, 0);
        wait_tick("al_hit");
        hms("al_hit", 7, 0, 0);
        check("al_hit", {31'd0, alarm}, 1);
        step(2 * CLK_DIV);
        check("al_sticky", {31'd0, alarm}, 1);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        check("al_ack", {31'd0, alarm}, 0);
        load(7, 0, 0);
        check("al_load", {31'd0, alarm}, 0);
        load(6, 59, 59);
        align_tick();
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
        check("al_hit_ack", {31'd0, alarm}, 1);
        alarm_on = 1'b0;
        step(2);
        check("al_off", {31'd0, alarm}, 1);
        alarm_ack = 1'b1;
        step(1);
        alarm_ack = 1'b0;
`endif

        // Asynchronous reset mid-run.
        mode_12h = 1'b1;
        load(5, 4, 3);
        step(1);
        #1;
        rst_n = 1'b0;
        #1;
        hms("arst", 12, 0, 0);
        check("arst_pm", {31'd0, pm}, 0);
        check("arst_tick", {31'd0, sec_tick}, 0);
        check("arst_err", {31'd0, set_err}, 0);
        mode_12h = 1'b0;
        #1;
        check("arst_h24", {27'd0, hours}, 0);
        step(1);
        rst_n = 1'b1;
        step(CLK_DIV - 1);
        check("rel_sec0", {26'd0, seconds}, 0);
        step(1);
        check("rel_sec1", {26'd0, seconds}, 1);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
